// File: rtl/parity_frame_tx.sv
// Serialises {parity, data} words as start, data LSB first, parity, stop bits; tx drops on the edge after acceptance.
// Takes one word per valid/ready handshake while idle; din_ready stays low from acceptance through the last stop cycle.
module parity_frame_tx #(
  parameter int N            = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [TW-1:0] TMR_MAX   = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [N:0]    word_q, word_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          bit_end;

  assign bit_end = (tmr_q == TMR_MAX);

  // idx_q counts data bits in DATA and stop bits in STOP; it is zero elsewhere.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;

    if (state_q != IDLE) begin
      tmr_d = bit_end ? '0 : tmr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (din_valid) begin
          word_d  = din;
          tmr_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        idx_d = '0;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      tmr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only, so reset forces tx high without a clock.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = word_q[idx_q];
      PARITY:  tx = word_q[N];
      default: tx = 1'b1;
    endcase
  end

  assign din_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && bit_end && (idx_q == STOP_LAST);

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: a (N=4, CPB=4, 1 stop) and b (N=1, CPB=1, 2 stops) share clock and reset.
module tb_parity_frame_tx;

  typedef struct packed {
    logic tx;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] din_a;
  logic       valid_a;
  logic       ready_a, tx_a, busy_a, done_a;
  logic [1:0] din_b;
  logic       valid_b;
  logic       ready_b, tx_b, busy_b, done_b;

  exp_t qa[$];
  exp_t qb[$];
  int   total  = 0;
  int   passed = 0;
  int   acc_a  = 0;
  int   acc_b  = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.N(4), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(valid_a),
    .din_ready(ready_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  parity_frame_tx #(.N(1), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(valid_b),
    .din_ready(ready_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
  endtask

  // seq lists line bits in transmit order, first bit in the MSB.
  task automatic push_seq_a(input logic [6:0] seq);
    for (int i = 6; i >= 0; i--)
      for (int k = 0; k < 4; k++)
        qa.push_back('{tx: seq[i], done: (i == 0 && k == 3)});
  endtask

  task automatic push_seq_b(input logic [4:0] seq);
    for (int i = 4; i >= 0; i--)
      qb.push_back('{tx: seq[i], done: (i == 0)});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_a && ready_a) acc_a++;
      if (busy_a) begin
        if (qa.size() == 0) chk("a_unexpected_busy", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_tx", tx_a, e.tx);
          chk("a_frame_done", done_a, e.done);
        end
        chk("a_ready_busy", ready_a, 0);
      end else begin
        chk("a_idle_tx", tx_a, 1);
        chk("a_idle_ready", ready_a, 1);
        chk("a_idle_done", done_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_b && ready_b) acc_b++;
      if (busy_b) begin
        if (qb.size() == 0) chk("b_unexpected_busy", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_tx", tx_b, e.tx);
          chk("b_frame_done", done_b, e.done);
        end
        chk("b_ready_busy", ready_b, 0);
      end else begin
        chk("b_idle_tx", tx_b, 1);
        chk("b_idle_ready", ready_b, 1);
        chk("b_idle_done", done_b, 0);
      end
    end
  end

  task automatic send_a(input logic [4:0] w, input logic [6:0] seq);
    @(posedge clk); #1;
    din_a = w; valid_a = 1'b1;
    push_seq_a(seq);
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy_a && n < 200);
    chk(nm, busy_a, 0);
    chk({nm, "_queue_empty"}, qa.size(), 0);
  endtask

  task automatic wait_idle_b(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy_b && n < 200);
    chk(nm, busy_b, 0);
    chk({nm, "_queue_empty"}, qb.size(), 0);
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_a && n < 200);
    chk(nm, done_a, 1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; din_a = '0; valid_a = 1'b0; din_b = '0; valid_b = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_tx_b", tx_b, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy_a", busy_a, 0);

    // Single frame: start, data 0110 LSB first, parity 1, stop
    send_a(5'b1_0110, 7'b0_0110_1_1);
    wait_idle_a("single_frame");
    chk("single_acc", acc_a, 1);

    // Back-to-back with valid held high
    base = acc_a;
    @(posedge clk); #1;
    din_a = 5'b0_1111; valid_a = 1'b1;
    push_seq_a(7'b0_1111_0_1);
    push_seq_a(7'b0_1000_1_1);
    @(posedge clk); #1;
    din_a = 5'b1_0001;
    wait_done_a("b2b_first_done");
    @(negedge clk);
    chk("b2b_gap_busy", busy_a, 0);
    chk("b2b_gap_tx", tx_a, 1);
    @(negedge clk);
    chk("b2b_second_start_busy", busy_a, 1);
    chk("b2b_second_start_tx", tx_a, 0);
    @(posedge clk); #1;
    valid_a = 1'b0;
    wait_idle_a("b2b_end");
    chk("b2b_acceptances", acc_a - base, 2);

    // din scrambled every cycle after acceptance
    send_a(5'b0_1010, 7'b0_0101_0_1);
    repeat (30) begin
      din_a = 5'($urandom);
      @(posedge clk); #1;
    end
    wait_idle_a("stability");

    // Reset during DATA
    send_a(5'b1_0110, 7'b0_0110_1_1);
    repeat (8) @(posedge clk);
    chk("midrst_pre_busy", busy_a, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", tx_a, 1);
    chk("midrst_busy_async", busy_a, 0);
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_post_busy", busy_a, 0);
    chk("midrst_post_ready", ready_a, 1);
    send_a(5'b0_1111, 7'b0_1111_0_1);
    wait_idle_a("midrst_new_frame");

    // N=1, CPB=1, two stop bits; next word accepted on the 6th cycle
    base = acc_b;
    @(posedge clk); #1;
    din_b = 2'b1_0; valid_b = 1'b1;
    push_seq_b(5'b0_0_1_11);
    push_seq_b(5'b0_1_0_11);
    @(posedge clk); #1;
    din_b = 2'b0_1;
    repeat (5) @(negedge clk);
    chk("edge_done_5th", done_b, 1);
    @(negedge clk);
    chk("edge_ready_6th", ready_b, 1);
    @(posedge clk); #1;
    valid_b = 1'b0;
    wait_idle_b("edge_end");
    chk("edge_acceptances", acc_b - base, 2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
